// File: rtl/jtag_uart_arb_pkg.sv
// Shared definitions for the JTAG UART arbiter: FSM states, response codes,
// register addresses and register bit positions.
package jtag_uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CTRL_RD = 3'd1,
    DATA_WR = 3'd2,
    DATA_RD = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] RSP_OK    = 2'b00;
  localparam logic [1:0] RSP_EMPTY = 2'b01;
  localparam logic [1:0] RSP_DROP  = 2'b10;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int RVALID_BIT = 15;
  localparam int WSPACE_MSB = 31;
  localparam int WSPACE_LSB = 16;

endpackage

// File: rtl/jtag_uart_arb_rr_arb.sv
// Combinational round-robin picker: the first pending request at or after
// the pointer, wrapping around the requester range.
module rr_arb #(
  parameter int NR_REQ = 3
) (
  input  logic [NR_REQ-1:0]         req,
  input  logic [$clog2(NR_REQ)-1:0] ptr,
  output logic [$clog2(NR_REQ)-1:0] grant_idx,
  output logic                      any_valid
);
  localparam int IDX_W = $clog2(NR_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NR_REQ);
      if (!any_valid && req[cand]) begin
        grant_idx = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtag_uart_arb.sv
// Round-robin arbiter sharing one Avalon-MM JTAG UART among NR_REQ byte requesters.
// Define JTAG_UART_ARB_WSPACE_CHK_EN to poll WSPACE before writes (dropped after TIMEOUT empty polls).
module jtag_uart_arb
  import jtag_uart_arb_pkg::*;
#(
  parameter int NR_REQ  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NR_REQ-1:0]   req_valid,
  input  logic [NR_REQ-1:0]   req_write,
  input  logic [8*NR_REQ-1:0] req_wdata,
  output logic [NR_REQ-1:0]   req_done,
  output logic [7:0]          rsp_data,
  output logic [1:0]          rsp_status,
  output logic                av_chipselect,
  output logic                av_address,
  output logic                av_read_n,
  output logic                av_write_n,
  output logic [31:0]         av_writedata,
  input  logic [31:0]         av_readdata,
  input  logic                av_waitrequest
);
  localparam int IDX_W = $clog2(NR_REQ);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [7:0]       arb_wdata;
  logic             cmd_done;
  logic             unused_bits;

`ifdef JTAG_UART_ARB_WSPACE_CHK_EN
  logic [$clog2(TIMEOUT+1)-1:0] retry_cnt;
  logic [7:0]                   wdata_q;
  assign unused_bits = ^av_readdata[14:8];
`else
  assign unused_bits = ^{av_readdata[31:16], av_readdata[14:8], TIMEOUT > 0};
`endif

  rr_arb #(.NR_REQ(NR_REQ)) u_rr_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  always_comb begin
    arb_wdata = '0;
    for (int i = 0; i < NR_REQ; i++)
      if (arb_idx == IDX_W'(i)) arb_wdata = req_wdata[8*i +: 8];
  end

  assign cmd_done = av_chipselect && !av_waitrequest;
  assign req_done = (state == DONE) ? (NR_REQ'(1) << grant) : '0;

  // Avalon command signals are registered: raised on entering a bus state and
  // held untouched until the cycle that waitrequest is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      rsp_data      <= '0;
      rsp_status    <= RSP_OK;
      av_chipselect <= 1'b0;
      av_address    <= ADDR_DATA;
      av_read_n     <= 1'b1;
      av_write_n    <= 1'b1;
      av_writedata  <= '0;
`ifdef JTAG_UART_ARB_WSPACE_CHK_EN
      retry_cnt     <= '0;
      wdata_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant         <= arb_idx;
            av_chipselect <= 1'b1;
            if (req_write[arb_idx]) begin
`ifdef JTAG_UART_ARB_WSPACE_CHK_EN
              retry_cnt  <= '0;
              wdata_q    <= arb_wdata;
              av_address <= ADDR_CTRL;
              av_read_n  <= 1'b0;
              state      <= CTRL_RD;
`else
              av_address   <= ADDR_DATA;
              av_write_n   <= 1'b0;
              av_writedata <= {24'h0, arb_wdata};
              state        <= DATA_WR;
`endif
            end else begin
              av_address <= ADDR_DATA;
              av_read_n  <= 1'b0;
              state      <= DATA_RD;
            end
          end
        end
`ifdef JTAG_UART_ARB_WSPACE_CHK_EN
        // A deasserted chipselect here is the idle gap between WSPACE polls.
        CTRL_RD: begin
          if (!av_chipselect) begin
            av_chipselect <= 1'b1;
            av_address    <= ADDR_CTRL;
            av_read_n     <= 1'b0;
          end else if (!av_waitrequest) begin
            av_read_n <= 1'b1;
            if (av_readdata[WSPACE_MSB:WSPACE_LSB] != 16'h0) begin
              av_address   <= ADDR_DATA;
              av_write_n   <= 1'b0;
              av_writedata <= {24'h0, wdata_q};
              state        <= DATA_WR;
            end else if (int'(retry_cnt) + 1 >= TIMEOUT) begin
              av_chipselect <= 1'b0;
              rsp_data      <= '0;
              rsp_status    <= RSP_DROP;
              state         <= DONE;
            end else begin
              av_chipselect <= 1'b0;
              retry_cnt     <= retry_cnt + 1'b1;
            end
          end
        end
`endif
        DATA_WR: begin
          if (cmd_done) begin
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            rsp_data      <= '0;
            rsp_status    <= RSP_OK;
            state         <= DONE;
          end
        end
        DATA_RD: begin
          if (cmd_done) begin
            av_chipselect <= 1'b0;
            av_read_n     <= 1'b1;
            rsp_data      <= av_readdata[RVALID_BIT] ? av_readdata[7:0] : 8'h00;
            rsp_status    <= av_readdata[RVALID_BIT] ? RSP_OK : RSP_EMPTY;
            state         <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= (grant == IDX_W'(NR_REQ - 1)) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_uart_arb.sv
// Self-checking bench for jtag_uart_arb: behavioural Avalon slave plus a
// round-robin/response reference model, with directed and randomized scenarios.
`timescale 1ns/1ps
module tb_jtag_uart_arb;
  import jtag_uart_arb_pkg::*;

  localparam int NR  = 3;
  localparam int TMO = 3;
`ifdef JTAG_UART_ARB_WSPACE_CHK_EN
  localparam int CTRL_PER_WR = 1;
`else
  localparam int CTRL_PER_WR = 0;
`endif
  localparam int WR_BASE = 2 + CTRL_PER_WR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_write = '0;
  logic [8*NR-1:0] req_wdata = '0;
  logic [NR-1:0] req_done;
  logic [7:0]    rsp_data;
  logic [1:0]    rsp_status;
  logic          av_chipselect, av_address, av_read_n, av_write_n;
  logic [31:0]   av_writedata;
  logic [31:0]   av_readdata;
  logic          av_waitrequest;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ptr = 0;

  int          cfg_wait_ctrl = 0;
  int          cfg_wait_data = 0;
  logic [15:0] cfg_wspace = 16'h0040;
  logic [31:0] cfg_data = 32'h0;
  int          n_ctrl_rd, n_data_rd, n_data_wr, unstable, proto_err, last_wr_cycles;
  logic [31:0] last_wdata;

  jtag_uart_arb #(.NR_REQ(NR), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_wdata      (req_wdata),
    .req_done       (req_done),
    .rsp_data       (rsp_data),
    .rsp_status     (rsp_status),
    .av_chipselect  (av_chipselect),
    .av_address     (av_address),
    .av_read_n      (av_read_n),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest)
  );

  always #5 clk = ~clk;

  // Behavioural JTAG UART slave: per-command waitrequest budget, command log,
  // and a check that command signals stay put while stalled.
  initial begin : slave
    bit          fresh;
    int          left;
    int          cyc;
    logic [34:0] snap;
    fresh = 1'b1; left = 0; cyc = 0; snap = '0;
    av_waitrequest = 1'b0;
    av_readdata = '0;
    forever begin
      @(negedge clk);
      if (av_chipselect && !reset) begin
        if (fresh) begin
          fresh = 1'b0;
          cyc = 0;
          snap = {av_address, av_read_n, av_write_n, av_writedata};
          left = av_address ? cfg_wait_ctrl : cfg_wait_data;
          if (av_read_n == av_write_n) proto_err++;
          if (!av_read_n && av_address) n_ctrl_rd++;
          else if (!av_read_n) n_data_rd++;
          else if (!av_write_n) begin
            if (av_address) proto_err++;
            n_data_wr++;
          end
        end else if (snap !== {av_address, av_read_n, av_write_n, av_writedata}) begin
          unstable++;
        end
        cyc++;
        if (left > 0) begin
          av_waitrequest = 1'b1;
          left--;
        end else begin
          av_waitrequest = 1'b0;
          av_readdata = av_address ? {cfg_wspace, cfg_data[15:0]} : cfg_data;
          fresh = 1'b1;
          if (!av_write_n) begin
            last_wdata = av_writedata;
            last_wr_cycles = cyc;
          end
        end
      end else begin
        av_waitrequest = 1'b0;
        fresh = 1'b1;
        left = 0;
      end
    end
  end

  function automatic int rr_pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++)
      if (m[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic clear_log();
    n_ctrl_rd = 0; n_data_rd = 0; n_data_wr = 0;
    unstable = 0; proto_err = 0; last_wr_cycles = 0; last_wdata = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
  endtask

  // Drives one request set from an idle DUT and waits (bounded) for req_done.
  task automatic run_txn(input logic [NR-1:0] valid, input logic [NR-1:0] wr,
                         input logic [8*NR-1:0] wd, input bit drop_early,
                         output int idx, output logic [7:0] data, output logic [1:0] status,
                         output int lat, output logic [NR-1:0] after, output bit hung);
    @(negedge clk);
    req_valid = valid; req_write = wr; req_wdata = wd;
    idx = -1; data = '0; status = '0; lat = 0; hung = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (drop_early && c == 1) begin
        req_valid = '0;
        req_write = ~wr;
        req_wdata = {$urandom, $urandom};
      end
      if (req_done != '0) begin
        idx = -2;
        for (int i = 0; i < NR; i++) if (req_done == (NR'(1) << i)) idx = i;
        data = rsp_data; status = rsp_status; lat = c; hung = 1'b0;
        break;
      end
    end
    req_valid = '0;
    @(posedge clk); #1;
    after = req_done;
  endtask

  task automatic test_reset();
    logic [48:0] got, want;
    want = {3'b000, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    reset = 1'b1;
    req_valid = 3'b111; req_write = 3'b101; req_wdata = 24'hA5C3F0;
    repeat (3) @(negedge clk);
    got = {req_done, rsp_data, rsp_status, av_chipselect, av_read_n, av_write_n, av_address, av_writedata};
    n_cmp++;
    if (got !== want) begin n_bad++; $display("[TB] FAIL reset_hold: got %h want %h", got, want); end
    req_valid = '0; req_write = '0; req_wdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    got = {req_done, rsp_data, rsp_status, av_chipselect, av_read_n, av_write_n, av_address, av_writedata};
    n_cmp++;
    if (got !== want) begin n_bad++; $display("[TB] FAIL reset_release: got %h want %h", got, want); end
    model_ptr = 0;
  endtask

  task automatic test_single_read();
    int idx, lat; logic [7:0] d; logic [1:0] st; logic [NR-1:0] aft; bit hung;
    clear_log();
    cfg_wait_data = 0; cfg_data = 32'h0000_8041;
    run_txn(3'b001, 3'b000, 24'h0, 1'b0, idx, d, st, lat, aft, hung);
    n_cmp++; if (hung) begin n_bad++; $display("[TB] FAIL read_timeout: no req_done within 200 cycles"); end
    n_cmp++; if (idx !== 0) begin n_bad++; $display("[TB] FAIL read_grant: got %0d want 0", idx); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("[TB] FAIL read_latency: got %0d want 2", lat); end
    n_cmp++; if (d !== 8'h41) begin n_bad++; $display("[TB] FAIL read_data: got %h want 41", d); end
    n_cmp++; if (st !== RSP_OK) begin n_bad++; $display("[TB] FAIL read_status: got %b want 00", st); end
    n_cmp++; if (aft !== '0) begin n_bad++; $display("[TB] FAIL read_pulse_width: got %b want 000", aft); end
    n_cmp++; if (n_data_rd !== 1) begin n_bad++; $display("[TB] FAIL read_cmd_count: got %0d want 1", n_data_rd); end
    model_ptr = 1;
  endtask

  task automatic test_empty_read();
    int idx, lat, w; logic [7:0] d; logic [1:0] st; logic [NR-1:0] aft; bit hung;
    clear_log();
    w = $urandom_range(0, 3);
    cfg_wait_data = w;
    cfg_data = $urandom;
    cfg_data[15] = 1'b0;
    cfg_data[0] = 1'b1;
    run_txn(3'b010, 3'b000, 24'h0, 1'b0, idx, d, st, lat, aft, hung);
    n_cmp++; if (idx !== 1) begin n_bad++; $display("[TB] FAIL empty_grant: got %0d want 1", idx); end
    n_cmp++; if (lat !== 2 + w) begin n_bad++; $display("[TB] FAIL empty_latency: got %0d want %0d", lat, 2 + w); end
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("[TB] FAIL empty_data: got %h want 00", d); end
    n_cmp++; if (st !== RSP_EMPTY) begin n_bad++; $display("[TB] FAIL empty_status: got %b want 01", st); end
    model_ptr = 2;
  endtask

  task automatic test_write_wait();
    int idx, lat; logic [7:0] d; logic [1:0] st; logic [NR-1:0] aft; bit hung;
    logic [8*NR-1:0] wd;
    clear_log();
    cfg_wait_ctrl = 0; cfg_wait_data = 4;
    cfg_wspace = 16'($urandom_range(1, 65535));
    wd = {8'h5A, 16'($urandom)};
    run_txn(3'b100, 3'b100, wd, 1'b1, idx, d, st, lat, aft, hung);
    n_cmp++; if (idx !== 2) begin n_bad++; $display("[TB] FAIL wr_grant: got %0d want 2", idx); end
    n_cmp++; if (lat !== WR_BASE + 4) begin n_bad++; $display("[TB] FAIL wr_latency: got %0d want %0d", lat, WR_BASE + 4); end
    n_cmp++; if (st !== RSP_OK) begin n_bad++; $display("[TB] FAIL wr_status: got %b want 00", st); end
    n_cmp++; if (n_data_wr !== 1) begin n_bad++; $display("[TB] FAIL wr_count: got %0d want 1", n_data_wr); end
    n_cmp++; if (last_wdata !== 32'h0000_005A) begin n_bad++; $display("[TB] FAIL wr_data: got %h want 0000005a", last_wdata); end
    n_cmp++; if (last_wr_cycles !== 5) begin n_bad++; $display("[TB] FAIL wr_hold_cycles: got %0d want 5", last_wr_cycles); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("[TB] FAIL wr_stable: got %0d changes want 0", unstable); end
    n_cmp++; if (n_ctrl_rd !== CTRL_PER_WR) begin n_bad++; $display("[TB] FAIL wr_ctrl_reads: got %0d want %0d", n_ctrl_rd, CTRL_PER_WR); end
    cfg_wait_data = 0;
    model_ptr = 0;
  endtask

  task automatic test_round_robin();
    int got_n, idx, exp; logic [7:0] exp_d;
    pulse_reset();
    clear_log();
    cfg_wait_ctrl = 0; cfg_wait_data = 0;
    cfg_data = $urandom;
    cfg_data[15] = 1'b1;
    exp_d = cfg_data[7:0];
    got_n = 0;
    @(negedge clk);
    req_valid = 3'b111; req_write = 3'b000;
    for (int c = 0; c < 100 && got_n < 4; c++) begin
      @(posedge clk); #1;
      if (req_done != '0) begin
        idx = -2;
        for (int i = 0; i < NR; i++) if (req_done == (NR'(1) << i)) idx = i;
        exp = rr_pick(3'b111, model_ptr);
        n_cmp++;
        if (idx !== exp) begin n_bad++; $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", got_n, idx, exp); end
        n_cmp++;
        if (rsp_data !== exp_d) begin n_bad++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", got_n, rsp_data, exp_d); end
        model_ptr = (exp + 1) % NR;
        got_n++;
        if (got_n == 4) req_valid = '0;
      end
    end
    req_valid = '0;
    n_cmp++;
    if (got_n !== 4) begin n_bad++; $display("[TB] FAIL rr_count: got %0d grants want 4", got_n); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int idx, lat, exp; logic [7:0] d; logic [1:0] st; logic [NR-1:0] aft; bit hung;
    clear_log();
    cfg_wait_ctrl = 0; cfg_wait_data = 0; cfg_wspace = 16'h0000;
    exp = rr_pick(3'b001, model_ptr);
    run_txn(3'b001, 3'b001, {16'h0, 8'hC3}, 1'b0, idx, d, st, lat, aft, hung);
    n_cmp++; if (idx !== exp) begin n_bad++; $display("[TB] FAIL tmo_grant: got %0d want %0d", idx, exp); end
`ifdef JTAG_UART_ARB_WSPACE_CHK_EN
    n_cmp++; if (st !== RSP_DROP) begin n_bad++; $display("[TB] FAIL tmo_status: got %b want 10", st); end
    n_cmp++; if (n_ctrl_rd !== TMO) begin n_bad++; $display("[TB] FAIL tmo_ctrl_reads: got %0d want %0d", n_ctrl_rd, TMO); end
    n_cmp++; if (n_data_wr !== 0) begin n_bad++; $display("[TB] FAIL tmo_no_write: got %0d want 0", n_data_wr); end
`else
    n_cmp++; if (st !== RSP_OK) begin n_bad++; $display("[TB] FAIL nochk_status: got %b want 00", st); end
    n_cmp++; if (n_ctrl_rd !== 0) begin n_bad++; $display("[TB] FAIL nochk_ctrl_reads: got %0d want 0", n_ctrl_rd); end
    n_cmp++; if (n_data_wr !== 1) begin n_bad++; $display("[TB] FAIL nochk_write: got %0d want 1", n_data_wr); end
`endif
    cfg_wspace = 16'h0040;
    model_ptr = (exp + 1) % NR;
  endtask

  task automatic test_reset_mid();
    int idx, lat; logic [7:0] d; logic [1:0] st; logic [NR-1:0] aft, seen; bit hung;
    clear_log();
    cfg_wait_data = 20;
    cfg_data = 32'h0000_80EE;
    @(negedge clk);
    req_valid = 3'b100; req_write = 3'b000;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (av_chipselect !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_busy: cs got %b want 1", av_chipselect); end
    reset = 1'b1;
    #1;
    n_cmp++; if (av_chipselect !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_cs_drop: cs got %b want 0", av_chipselect); end
    req_valid = '0;
    seen = req_done;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    cfg_wait_data = 0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; seen |= req_done; end
    n_cmp++; if (seen !== '0) begin n_bad++; $display("[TB] FAIL mid_no_done: got %b want 000", seen); end
    run_txn(3'b111, 3'b000, 24'h0, 1'b0, idx, d, st, lat, aft, hung);
    n_cmp++; if (idx !== 0) begin n_bad++; $display("[TB] FAIL mid_next_grant: got %0d want 0", idx); end
    n_cmp++; if (d !== 8'hEE) begin n_bad++; $display("[TB] FAIL mid_next_data: got %h want ee", d); end
    model_ptr = 1;
  endtask

  task automatic test_random();
    int idx, lat, exp, wc, wdl, exp_lat; logic [7:0] d, exp_d, exp_b; logic [1:0] st, exp_st;
    logic [NR-1:0] aft, mask, wr; logic [8*NR-1:0] wd; bit hung, drop, is_wr;
    for (int t = 0; t < 40; t++) begin
      clear_log();
      mask = NR'($urandom_range(1, 7));
      wr = NR'($urandom);
      wd = 24'($urandom);
      wc = $urandom_range(0, 3);
      wdl = $urandom_range(0, 3);
      drop = 1'($urandom_range(0, 1));
      cfg_wait_ctrl = wc; cfg_wait_data = wdl;
      cfg_wspace = 16'($urandom_range(1, 65535));
      cfg_data = $urandom;
      exp = rr_pick(mask, model_ptr);
      is_wr = wr[exp];
      exp_b = wd[8*exp +: 8];
      exp_lat = is_wr ? (WR_BASE + CTRL_PER_WR * wc + wdl) : (2 + wdl);
      exp_st = (is_wr || cfg_data[15]) ? RSP_OK : RSP_EMPTY;
      exp_d = cfg_data[15] ? cfg_data[7:0] : 8'h00;
      run_txn(mask, wr, wd, drop, idx, d, st, lat, aft, hung);
      n_cmp++; if (idx !== exp) begin n_bad++; $display("[TB] FAIL rnd_grant[%0d]: got %0d want %0d", t, idx, exp); end
      n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("[TB] FAIL rnd_latency[%0d]: got %0d want %0d", t, lat, exp_lat); end
      n_cmp++; if (st !== exp_st) begin n_bad++; $display("[TB] FAIL rnd_status[%0d]: got %b want %b", t, st, exp_st); end
      n_cmp++; if (aft !== '0) begin n_bad++; $display("[TB] FAIL rnd_pulse[%0d]: got %b want 000", t, aft); end
      if (is_wr) begin
        n_cmp++; if (n_data_wr !== 1 || last_wdata !== {24'h0, exp_b})
          begin n_bad++; $display("[TB] FAIL rnd_write[%0d]: got %0d writes data %h want 1 write data %h", t, n_data_wr, last_wdata, {24'h0, exp_b}); end
      end else begin
        n_cmp++; if (d !== exp_d || n_data_wr !== 0)
          begin n_bad++; $display("[TB] FAIL rnd_read[%0d]: got %h (%0d writes) want %h (0 writes)", t, d, n_data_wr, exp_d); end
      end
      n_cmp++; if (proto_err !== 0 || unstable !== 0)
        begin n_bad++; $display("[TB] FAIL rnd_bus[%0d]: got %0d protocol / %0d stability errors want 0", t, proto_err, unstable); end
      model_ptr = (exp + 1) % NR;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    clear_log();
    test_reset();
    test_single_read();
    test_empty_read();
    test_write_wait();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_uart_arb.md
JTAG_UART_ARB -- requirements
Module: jtag_uart_arb

Interface
REQ-001 The block SHALL have parameter NR_REQ, default 3, the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, the maximum consecutive WSPACE=0 retries per write before it is dropped.
REQ-003 The block SHALL have ports clk  in  1  sole clock, all logic on rising edge.
REQ-004 The block SHALL have ports reset  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports req_valid  in  NR_REQ  per-requester request pending.
REQ-006 The block SHALL have ports req_write  in  NR_REQ  1=write byte, 0=read byte.
REQ-007 The block SHALL have ports req_wdata  in  8*NR_REQ  write byte, requester i at bits [8i+7:8i].
REQ-008 The block SHALL have ports req_done  out  NR_REQ  one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have ports rsp_data  out  8  read byte, valid with req_done.
REQ-010 The block SHALL have ports rsp_status  out  2  00=ok, 01=read empty (RVALID=0), 10=write dropped (timeout).
REQ-011 The block SHALL have ports av_chipselect, av_address (1), av_read_n, av_write_n, av_writedata (32)  out  Avalon-MM master to the JTAG UART slave.
REQ-012 The block SHALL have ports av_readdata (32), av_waitrequest (1)  in  Avalon-MM slave response.

Function
REQ-013 The FSM SHALL have states IDLE, CTRL_RD, DATA_WR, DATA_RD, DONE.
REQ-014 IDLE: the block SHALL grant the lowest index at or after rr_ptr with req_valid=1; no request keeps it in IDLE.
REQ-015 On grant: write -> CTRL_RD, read -> DATA_RD; grant index and wdata are latched, and later changes to req_* are ignored.
REQ-016 An Avalon command SHALL hold chipselect, address, read_n/write_n and writedata stable while av_waitrequest=1, and complete in the first cycle with av_waitrequest=0; readdata is sampled in that cycle.
REQ-017 CTRL_RD reads address 1; WSPACE=readdata[31:16]; WSPACE!=0 -> DATA_WR, WSPACE=0 -> retry_cnt+1 and re-enter CTRL_RD after one idle cycle.
REQ-018 retry_cnt reaching TIMEOUT SHALL go to DONE with rsp_status=10 and no data write; retry_cnt clears on every grant.
REQ-019 DATA_WR writes {24'h0, wdata} to address 0, then -> DONE with rsp_status=00.
REQ-020 DATA_RD reads address 0: RVALID=readdata[15]; rsp_data=readdata[7:0] if RVALID else 8'h00; rsp_status=00 or 01.
REQ-021 DONE lasts exactly one cycle, pulses req_done[grant], sets rr_ptr=(grant+1) mod NR_REQ, -> IDLE.
REQ-022 Best-case latency, grant to req_done: write 3 cycles, read 2 cycles (zero waitrequest).
REQ-023 req_valid deasserted mid-transaction SHALL NOT abort it; req_done still pulses.
REQ-024 Only one Avalon command SHALL be outstanding; the bus is idle (chipselect=0) in IDLE and DONE.

Reset
REQ-025 Reset SHALL force: state=IDLE, rr_ptr=0, retry_cnt=0, req_done=0, rsp_data=0, rsp_status=00, av_chipselect=0, av_read_n=1, av_write_n=1, av_address=0, av_writedata=0.
REQ-026 Reset asserted mid-transaction SHALL abandon it immediately; no req_done is issued for it.

Configuration
REQ-027 Macro JTAG_UART_ARB_WSPACE_CHK_EN defined: the CTRL_RD flow-control of REQ-017/018 is present.
REQ-028 Macro undefined: a write grant SHALL go directly to DATA_WR, TIMEOUT is unused, and rsp_status=10 never occurs.

Structure
REQ-029 Package jtag_uart_arb_pkg SHALL hold the FSM state enum, rsp_status codes, the address constants (DATA=0, CTRL=1) and the bit positions (RVALID=15, WSPACE=31:16).
REQ-030 Round-robin selection SHALL be sub-module rr_arb (inputs: req vector and pointer; outputs: grant index and any-valid), purely combinational.

Verification
REQ-031 Single read, readdata=32'h0000_8041, no waitrequest -> req_done[0] 2 cycles after grant, rsp_data=8'h41, rsp_status=00.
REQ-032 Requesters 0,1,2 all valid continuously -> grants in order 0,1,2,0; no requester is granted twice before the others.
REQ-033 Write 8'h5A with av_waitrequest=1 for 4 cycles on DATA_WR -> writedata=32'h5A held stable for 5 cycles, single write, status 00.
REQ-034 WSPACE_CHK_EN, TIMEOUT=3, WSPACE=0 always -> 3 control reads, no address-0 write, req_done with rsp_status=10.
REQ-035 Read with readdata[15]=0 -> rsp_data=8'h00, rsp_status=01.
REQ-036 reset pulsed during DATA_RD waitrequest -> chipselect=0 the same cycle, no req_done, next grant goes to requester 0.
